// File: rtl/sdram_rw_arbiter.sv
// Two-client SDRAM read/write port arbiter: IDLE -> BUSY -> RELEASE, start pulse in first BUSY cycle.
// Define SDRAM_ARB_RR_EN for round-robin between simultaneous requests; default is fixed priority (client 0).
module sdram_rw_arbiter #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              c0_req,
    input  logic              c0_wr,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [CNT_W-1:0]  c0_cnt,
    output logic              c0_gnt,
    output logic              c0_done,
    output logic              c0_read_valid,
    output logic [DATA_W-1:0] c0_read_data,
    output logic              c0_write_nxt,
    input  logic [DATA_W-1:0] c0_write_data,

    input  logic              c1_req,
    input  logic              c1_wr,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [CNT_W-1:0]  c1_cnt,
    output logic              c1_gnt,
    output logic              c1_done,
    output logic              c1_read_valid,
    output logic [DATA_W-1:0] c1_read_data,
    output logic              c1_write_nxt,
    input  logic [DATA_W-1:0] c1_write_data,

    output logic [ADDR_W-1:0] rw_addr,
    output logic [CNT_W-1:0]  rw_cnt,
    output logic              read_start,
    output logic              write_start,
    input  logic              rw_done,
    input  logic              read_valid,
    input  logic [DATA_W-1:0] read_data,
    input  logic              write_nxt,
    output logic [DATA_W-1:0] write_data
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                zero_q, zero_d;
    logic                rd_start_q, rd_start_d;
    logic                wr_start_q, wr_start_d;
    logic [ADDR_W-1:0]   rw_addr_q, rw_addr_d;
    logic [CNT_W-1:0]    rw_cnt_q, rw_cnt_d;
    logic                win;
    logic                sel_wr;
    logic [CNT_W-1:0]    sel_cnt;
    logic                busy;
    logic                done_w;

`ifdef SDRAM_ARB_RR_EN
    logic                ptr_q, ptr_d;

    // Pointer holds the last winner; on a tie the other client goes next.
    always_comb begin
        win   = (c0_req && c1_req) ? ~ptr_q : c1_req;
        ptr_d = ptr_q;
        if (state_q == IDLE && (c0_req || c1_req)) begin
            ptr_d = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win = ~c0_req;
    end
`endif

    assign sel_wr  = win ? c1_wr  : c0_wr;
    assign sel_cnt = win ? c1_cnt : c0_cnt;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        zero_d     = zero_q;
        rw_addr_d  = rw_addr_q;
        rw_cnt_d   = rw_cnt_q;
        rd_start_d = 1'b0;
        wr_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (c0_req || c1_req) begin
                    owner_d    = win;
                    rw_addr_d  = win ? c1_addr : c0_addr;
                    rw_cnt_d   = sel_cnt;
                    zero_d     = (sel_cnt == '0);
                    rd_start_d = (sel_cnt != '0) && !sel_wr;
                    wr_start_d = (sel_cnt != '0) && sel_wr;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Zero-count transfers complete on their own without the wrapper.
                if (zero_q || rw_done) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            zero_q     <= 1'b0;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            rw_addr_q  <= '0;
            rw_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            zero_q     <= zero_d;
            rd_start_q <= rd_start_d;
            wr_start_q <= wr_start_d;
            rw_addr_q  <= rw_addr_d;
            rw_cnt_q   <= rw_cnt_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign done_w = busy && (zero_q || rw_done);

    assign c0_gnt        = busy && !owner_q;
    assign c1_gnt        = busy &&  owner_q;
    assign c0_done       = done_w && !owner_q;
    assign c1_done       = done_w &&  owner_q;
    assign c0_read_valid = c0_gnt && read_valid;
    assign c1_read_valid = c1_gnt && read_valid;
    assign c0_write_nxt  = c0_gnt && write_nxt;
    assign c1_write_nxt  = c1_gnt && write_nxt;
    assign c0_read_data  = read_data;
    assign c1_read_data  = read_data;
    assign write_data    = owner_q ? c1_write_data : c0_write_data;

    assign rw_addr     = rw_addr_q;
    assign rw_cnt      = rw_cnt_q;
    assign read_start  = rd_start_q;
    assign write_start = wr_start_q;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Randomized bench for sdram_rw_arbiter; the bench plays both clients and the SDRAM wrapper.
module tb_sdram_rw_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [1:0]   wr = 2'b00;
    logic [31:0]  addr [2];
    logic [15:0]  cnt [2];
    logic [127:0] wdat [2];
    logic [127:0] rdat = '0;
    logic         rw_done = 1'b0, read_valid = 1'b0, write_nxt = 1'b0;

    logic         c0_gnt, c0_done, c0_read_valid, c0_write_nxt;
    logic         c1_gnt, c1_done, c1_read_valid, c1_write_nxt;
    logic [127:0] c0_read_data, c1_read_data, write_data;
    logic [31:0]  rw_addr;
    logic [15:0]  rw_cnt;
    logic         read_start, write_start;

    int checks = 0;
    int errors = 0;
    bit last_w = 1'b1;
`ifdef SDRAM_ARB_RR_EN
    bit rr = 1'b1;
`else
    bit rr = 1'b0;
`endif

    sdram_rw_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(req[0]), .c0_wr(wr[0]), .c0_addr(addr[0]), .c0_cnt(cnt[0]),
        .c0_gnt(c0_gnt), .c0_done(c0_done), .c0_read_valid(c0_read_valid),
        .c0_read_data(c0_read_data), .c0_write_nxt(c0_write_nxt), .c0_write_data(wdat[0]),
        .c1_req(req[1]), .c1_wr(wr[1]), .c1_addr(addr[1]), .c1_cnt(cnt[1]),
        .c1_gnt(c1_gnt), .c1_done(c1_done), .c1_read_valid(c1_read_valid),
        .c1_read_data(c1_read_data), .c1_write_nxt(c1_write_nxt), .c1_write_data(wdat[1]),
        .rw_addr(rw_addr), .rw_cnt(rw_cnt), .read_start(read_start), .write_start(write_start),
        .rw_done(rw_done), .read_valid(read_valid), .read_data(rdat), .write_nxt(write_nxt),
        .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Entered just after an IDLE-cycle negedge with client inputs already driven;
    // returns just after the negedge of the following IDLE cycle.
    task automatic run_xfer(input bit early, input bit hold, output bit ow);
        bit          w;
        bit          ew;
        logic [15:0] ec;
        logic [31:0] ea;
        logic [1:0]  oh;
        int          n;
        int          gaps;
        bit          beat;
        bit          fin;
        #1;
        chk("idle_gnt", {c1_gnt, c0_gnt}, 2'b00);
        w = (req == 2'b11) ? (rr ? ~last_w : 1'b0) : req[1];
        last_w = w;
        ew = wr[w];
        ec = cnt[w];
        ea = addr[w];
        oh = w ? 2'b10 : 2'b01;
        fin = (ec == 0) || early;

        @(negedge clk);
        if (!hold) req[~w] = 1'b0;
        rw_done = early && (ec != 0);
        #1;
        ow = c1_gnt;
        chk("gnt", {c1_gnt, c0_gnt}, oh);
        chk("start", {read_start, write_start}, (ec == 0) ? 2'b00 : (ew ? 2'b01 : 2'b10));
        chk("rw_addr", rw_addr, ea);
        chk("rw_cnt", rw_cnt, ec);
        chk("done_first", {c1_done, c0_done}, fin ? oh : 2'b00);

        if (!fin) begin
            n = 0;
            gaps = 0;
            while (n < ec) begin
                @(negedge clk);
                beat = ($urandom % 4 != 0) || (gaps >= 3);
                gaps = beat ? 0 : gaps + 1;
                rdat = {$urandom, $urandom, $urandom, $urandom};
                wdat[0] = {$urandom, $urandom, $urandom, $urandom};
                wdat[1] = {$urandom, $urandom, $urandom, $urandom};
                read_valid = beat && !ew;
                write_nxt  = beat && ew;
                #1;
                chk("rd_valid", {c1_read_valid, c0_read_valid}, (beat && !ew) ? oh : 2'b00);
                chk("wr_nxt", {c1_write_nxt, c0_write_nxt}, (beat && ew) ? oh : 2'b00);
                chk("rd_data", {c1_read_data ^ c0_read_data, c0_read_data}, {128'd0, rdat});
                chk("wr_data", write_data, wdat[w]);
                chk("start_once", {read_start, write_start}, 2'b00);
                chk("done_early", {c1_done, c0_done}, 2'b00);
                if (beat) n++;
            end
            @(negedge clk);
            read_valid = 1'b0;
            write_nxt  = 1'b0;
            rw_done    = 1'b1;
            #1;
            chk("done", {c1_done, c0_done}, oh);
            chk("gnt_done", {c1_gnt, c0_gnt}, oh);
        end

        @(negedge clk);
        rw_done    = $urandom % 2;
        read_valid = $urandom % 2;
        write_nxt  = $urandom % 2;
        if (!hold) req = 2'b00;
        #1;
        chk("rel_gnt", {c1_gnt, c0_gnt}, 2'b00);
        chk("rel_out", {c1_done, c0_done, c1_read_valid, c0_read_valid,
                        c1_write_nxt, c0_write_nxt, read_start, write_start}, 8'd0);
        chk("rel_addr", rw_addr, ea);
        rw_done    = 1'b0;
        read_valid = 1'b0;
        write_nxt  = 1'b0;
        @(negedge clk);
    endtask

    bit       ow;
    bit [2:0] seq;

    initial begin
        addr[0] = '0; addr[1] = '0; cnt[0] = '0; cnt[1] = '0;
        wdat[0] = '0; wdat[1] = '0;
        repeat (2) @(negedge clk);
        read_valid = 1'b1;
        rw_done    = 1'b1;
        #1;
        chk("rst_out", {c1_gnt, c0_gnt, c1_done, c0_done, c1_read_valid, c0_read_valid,
                        c1_write_nxt, c0_write_nxt, read_start, write_start}, 10'd0);
        chk("rst_desc", {rw_addr, rw_cnt}, 48'd0);
        read_valid = 1'b0;
        rw_done    = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        // c0 read of 4 beats
        req = 2'b01; wr = 2'b00; addr[0] = 32'h2000_0000; cnt[0] = 16'd4;
        run_xfer(1'b0, 1'b0, ow);
        // c1 write of 3 beats
        req = 2'b10; wr = 2'b10; addr[1] = 32'h1234_5670; cnt[1] = 16'd3;
        run_xfer(1'b0, 1'b0, ow);

        // both requesting and held across three grants
        req = 2'b11; wr = 2'b00; cnt[0] = 16'd2; cnt[1] = 16'd2;
        addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            run_xfer(1'b0, 1'b1, ow);
            seq[i] = ow;
        end
        req = 2'b00;
        chk("tie_seq", seq, rr ? 3'b010 : 3'b000);

        // zero-count request
        req = 2'b01; cnt[0] = 16'd0; wr = 2'b01;
        run_xfer(1'b0, 1'b0, ow);

        // spurious wrapper activity in IDLE
        rw_done = 1'b1; read_valid = 1'b1; write_nxt = 1'b1;
        #1;
        chk("idle_spur", {c1_gnt, c0_gnt, c1_done, c0_done, c1_read_valid, c0_read_valid,
                          c1_write_nxt, c0_write_nxt}, 8'd0);
        @(negedge clk);
        rw_done = 1'b0; read_valid = 1'b0; write_nxt = 1'b0;
        #1;
        chk("idle_stay", {c1_gnt, c0_gnt, read_start, write_start}, 4'd0);

        // reset in the middle of an 8-beat read
        req = 2'b01; wr = 2'b00; addr[0] = 32'h0BAD_F00D; cnt[0] = 16'd8;
        @(negedge clk);
        #1;
        chk("mid_gnt", {c1_gnt, c0_gnt}, 2'b01);
        repeat (2) begin
            @(negedge clk);
            read_valid = 1'b1;
            #1;
            chk("mid_beat", c0_read_valid, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out", {c1_gnt, c0_gnt, c1_done, c0_done, c1_read_valid, c0_read_valid,
                          read_start, write_start}, 8'd0);
        chk("abort_desc", {rw_addr, rw_cnt}, 48'd0);
        req = 2'b00; read_valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        last_w = 1'b1;
        @(negedge clk);
        req = 2'b10; wr = 2'b10; addr[1] = 32'h0000_4000; cnt[1] = 16'd2;
        run_xfer(1'b0, 1'b0, ow);

        // randomized transfers
        for (int i = 0; i < 40; i++) begin
            req = 2'($urandom_range(1, 3));
            wr  = 2'($urandom);
            addr[0] = $urandom; addr[1] = $urandom;
            cnt[0] = 16'($urandom_range(0, 6));
            cnt[1] = 16'($urandom_range(0, 6));
            run_xfer($urandom % 6 == 0, 1'b0, ow);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
